// File: rtl/vend_controller_if.sv
// vend_controller_if: front-end/dispenser signal bundle for vend_controller.
//   master: selection, coin, cancel and disp_ack inputs; observes the outputs.
//   slave:  the controller; drives product, change, coin_reject, err_item,
//           busy and credit.
interface vend_controller_if;
  logic [3:0] item_no;
  logic       sel_valid;
  logic       five_rup;
  logic       ten_rup;
  logic       cancel;
  logic       disp_ack;
  logic       product;
  logic       change;
  logic       coin_reject;
  logic       err_item;
  logic       busy;
  logic [3:0] credit;
  modport master (
    output item_no, sel_valid, five_rup, ten_rup, cancel, disp_ack,
    input  product, change, coin_reject, err_item, busy, credit
  );
  modport slave (
    input  item_no, sel_valid, five_rup, ten_rup, cancel, disp_ack,
    output product, change, coin_reject, err_item, busy, credit
  );
endinterface

// File: rtl/vend_controller.sv
// vend_controller: vending transaction sequencer (select, collect, dispense, change/refund).
//   clk   rising-edge clock
//   rst_n asynchronous active-low reset
//   bus   vend_controller_if.slave: selection/coin/cancel/disp_ack in;
//         product, change, busy, credit (registered) and coin_reject,
//         err_item (combinational) out. Credit and prices are in 5-rupee units.
module vend_controller #(
  parameter int PRICE1         = 4,
  parameter int PRICE2         = 5,
  parameter int PRICE3         = 6,
  parameter int PRICE4         = 7,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic clk,
  input logic rst_n,
  vend_controller_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  if (PRICE1 < 1 || PRICE1 > 13 || PRICE2 < 1 || PRICE2 > 13 ||
      PRICE3 < 1 || PRICE3 > 13 || PRICE4 < 1 || PRICE4 > 13) begin : g_bad_price
    $error("vend_controller: every PRICEn must be in 1..13");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("vend_controller: TIMEOUT_CYCLES must be at least 2");
  end
  typedef enum logic [2:0] {IDLE, COLLECT, DISPENSE, CHANGE, REFUND} state_t;
  state_t         state;
  logic [3:0]     price;
  logic [TW-1:0]  tcnt;
  logic           coin;
  logic           valid;
  logic [1:0]     add;
  logic [4:0]     sum;
  logic [3:0]     sel_price;
  assign coin      = bus.five_rup | bus.ten_rup;
  assign valid     = $onehot(bus.item_no);
  assign add       = {1'b0, bus.five_rup} + {bus.ten_rup, 1'b0};
  assign sum       = {1'b0, bus.credit} + {3'b000, add};
  assign sel_price = bus.item_no == 4'b0001 ? 4'(PRICE1) :
                     bus.item_no == 4'b0010 ? 4'(PRICE2) :
                     bus.item_no == 4'b0100 ? 4'(PRICE3) :
                     bus.item_no == 4'b1000 ? 4'(PRICE4) : 4'd0;
  // Mealy outputs are gated by rst_n so every output reads 0 while in reset.
  assign bus.coin_reject = rst_n && coin && state != COLLECT;
  assign bus.err_item    = rst_n && state == IDLE && bus.sel_valid && !valid;
  // Moore outputs are registered: each transition sets them to the values
  // belonging to the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      price       <= '0;
      tcnt        <= '0;
      bus.credit  <= '0;
      bus.product <= 1'b0;
      bus.change  <= 1'b0;
      bus.busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.sel_valid && valid) begin
          state      <= COLLECT;
          price      <= sel_price;
          bus.credit <= '0;
          tcnt       <= '0;
          bus.busy   <= 1'b1;
        end
        COLLECT: begin
          bus.credit <= sum[3:0];
          tcnt       <= coin ? '0 : tcnt + TW'(1);
          // Reaching the price outranks a simultaneous cancel.
          if (sum >= {1'b0, price}) begin
            state       <= DISPENSE;
            bus.product <= 1'b1;
          end else if (bus.cancel || (!coin && tcnt == TW'(TIMEOUT_CYCLES - 1))) begin
            state      <= REFUND;
            bus.change <= sum != 5'd0;
          end
        end
        DISPENSE: if (bus.disp_ack) begin
          bus.product <= 1'b0;
          bus.credit  <= bus.credit - price;
          if (bus.credit != price) begin
            state      <= CHANGE;
            bus.change <= 1'b1;
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        CHANGE, REFUND: if (bus.credit > 4'd1) begin
          bus.credit <= bus.credit - 4'd1;
        end else begin
          // Last pulse (or an empty refund): IDLE with zero credit next cycle.
          state      <= IDLE;
          bus.credit <= '0;
          bus.change <= 1'b0;
          bus.busy   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller: table-driven scoreboard bench for vend_controller.
module tb_vend_controller;
  localparam int T = 1000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  vend_controller_if bus ();
  vend_controller #(.TIMEOUT_CYCLES(T)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    string      nm;
    logic       sel;
    logic [3:0] item;
    logic       five;
    logic       ten;
    logic       cncl;
    logic       ack;
    logic [8:0] exp;
  } vec_t;
  vec_t       vecs[$];
  logic [8:0] sb[$];
  int checks = 0;
  int errors = 0;
  function automatic vec_t v(input string nm, input logic sel, input logic [3:0] item,
                             input logic five, input logic ten, input logic cncl, input logic ack,
                             input logic p, input logic c, input logic rj, input logic er,
                             input logic b, input logic [3:0] cr);
    vec_t r;
    r.nm = nm; r.sel = sel; r.item = item; r.five = five; r.ten = ten;
    r.cncl = cncl; r.ack = ack; r.exp = {p, c, rj, er, b, cr};
    return r;
  endfunction
  function automatic logic [8:0] outs();
    return {bus.product, bus.change, bus.coin_reject, bus.err_item, bus.busy, bus.credit};
  endfunction
  task automatic cmp(input string nm, input logic [8:0] exp);
    logic [8:0] act;
    act = outs();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got prod/chg/rej/err/busy/credit=%b required %b", nm, act, exp);
    end
  endtask
  // One cycle: drive the row's inputs just after the edge, queue its expected
  // outputs, and compare at the falling edge.
  task automatic step(input vec_t r);
    @(posedge clk);
    #1;
    bus.sel_valid = r.sel; bus.item_no = r.item; bus.five_rup = r.five;
    bus.ten_rup = r.ten; bus.cancel = r.cncl; bus.disp_ack = r.ack;
    sb.push_back(r.exp);
    #4;
    cmp(r.nm, sb.pop_front());
  endtask
  initial begin
    bus.sel_valid = 1'b0; bus.item_no = '0; bus.five_rup = 1'b0;
    bus.ten_rup = 1'b0; bus.cancel = 1'b0; bus.disp_ack = 1'b0;
    vecs.push_back(v("rst",        0,4'h0, 0,0,0,0, 0,0,0,0,0,4'd0));
    vecs.push_back(v("a_sel",      1,4'h1, 0,0,0,0, 0,0,0,0,0,4'd0));
    vecs.push_back(v("a_ten1",     0,4'h0, 0,1,0,0, 0,0,0,0,1,4'd0));
    vecs.push_back(v("a_ten2_sel", 1,4'h8, 0,1,0,0, 0,0,0,0,1,4'd2));
    vecs.push_back(v("a_disp",     0,4'h0, 0,0,0,0, 1,0,0,0,1,4'd4));
    vecs.push_back(v("a_ack",      0,4'h0, 0,0,0,1, 1,0,0,0,1,4'd4));
    vecs.push_back(v("a_idle",     0,4'h0, 0,0,0,0, 0,0,0,0,0,4'd0));
    vecs.push_back(v("b_sel",      1,4'h2, 0,0,0,0, 0,0,0,0,0,4'd0));
    vecs.push_back(v("b_ten1",     0,4'h0, 0,1,0,0, 0,0,0,0,1,4'd0));
    vecs.push_back(v("b_ten2",     0,4'h0, 0,1,0,0, 0,0,0,0,1,4'd2));
    vecs.push_back(v("b_ten3",     0,4'h0, 0,1,0,0, 0,0,0,0,1,4'd4));
    vecs.push_back(v("b_disp",     0,4'h0, 0,0,0,0, 1,0,0,0,1,4'd6));
    vecs.push_back(v("b_ack",      0,4'h0, 0,0,0,1, 1,0,0,0,1,4'd6));
    vecs.push_back(v("b_chg",      0,4'h0, 0,0,0,0, 0,1,0,0,1,4'd1));
    vecs.push_back(v("b_idle",     0,4'h0, 0,0,0,0, 0,0,0,0,0,4'd0));
    vecs.push_back(v("c_sel",      1,4'h8, 0,0,0,0, 0,0,0,0,0,4'd0));
    vecs.push_back(v("c_both",     0,4'h0, 1,1,0,0, 0,0,0,0,1,4'd0));
    vecs.push_back(v("c_five",     0,4'h0, 1,0,0,0, 0,0,0,0,1,4'd3));
    vecs.push_back(v("c_cancel",   0,4'h0, 0,0,1,0, 0,0,0,0,1,4'd4));
    vecs.push_back(v("c_ref4",     0,4'h0, 0,0,0,0, 0,1,0,0,1,4'd4));
    vecs.push_back(v("c_ref3",     0,4'h0, 0,0,0,0, 0,1,0,0,1,4'd3));
    vecs.push_back(v("c_ref2",     0,4'h0, 0,0,0,0, 0,1,0,0,1,4'd2));
    vecs.push_back(v("c_ref1",     0,4'h0, 0,0,0,0, 0,1,0,0,1,4'd1));
    vecs.push_back(v("c_idle",     0,4'h0, 0,0,0,0, 0,0,0,0,0,4'd0));
    vecs.push_back(v("d_five_idle",0,4'h0, 1,0,0,0, 0,0,1,0,0,4'd0));
    vecs.push_back(v("d_ten_idle", 0,4'h0, 0,1,0,0, 0,0,1,0,0,4'd0));
    vecs.push_back(v("d_err_0011", 1,4'h3, 0,0,0,0, 0,0,0,1,0,4'd0));
    vecs.push_back(v("d_err_0000", 1,4'h0, 0,0,0,0, 0,0,0,1,0,4'd0));
    vecs.push_back(v("d_ack_idle", 0,4'h0, 0,0,0,1, 0,0,0,0,0,4'd0));
    vecs.push_back(v("d_idle",     0,4'h0, 0,0,0,0, 0,0,0,0,0,4'd0));
    vecs.push_back(v("e_sel",      1,4'h4, 0,0,0,0, 0,0,0,0,0,4'd0));
    vecs.push_back(v("e_ten_cncl", 0,4'h0, 0,1,1,0, 0,0,0,0,1,4'd0));
    vecs.push_back(v("e_ref2",     0,4'h0, 0,0,0,0, 0,1,0,0,1,4'd2));
    vecs.push_back(v("e_ref1",     0,4'h0, 0,0,0,0, 0,1,0,0,1,4'd1));
    vecs.push_back(v("e_idle",     0,4'h0, 0,0,0,0, 0,0,0,0,0,4'd0));
    vecs.push_back(v("f_sel",      1,4'h1, 0,0,0,0, 0,0,0,0,0,4'd0));
    vecs.push_back(v("f_ten",      0,4'h0, 0,1,0,0, 0,0,0,0,1,4'd0));
    vecs.push_back(v("f_ten_cncl", 0,4'h0, 0,1,1,0, 0,0,0,0,1,4'd2));
    vecs.push_back(v("f_disp",     0,4'h0, 0,0,0,0, 1,0,0,0,1,4'd4));
    vecs.push_back(v("f_ack",      0,4'h0, 0,0,0,1, 1,0,0,0,1,4'd4));
    vecs.push_back(v("f_idle",     0,4'h0, 0,0,0,0, 0,0,0,0,0,4'd0));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    foreach (vecs[i]) step(vecs[i]);
    // Timeout: one coin, then exactly T quiet cycles before the refund starts.
    step(v("t_sel",  1,4'h4, 0,0,0,0, 0,0,0,0,0,4'd0));
    step(v("t_five", 0,4'h0, 1,0,0,0, 0,0,0,0,1,4'd0));
    for (int i = 0; i < T; i++) step(v("t_wait", 0,4'h0, 0,0,0,0, 0,0,0,0,1,4'd1));
    step(v("t_ref1", 0,4'h0, 0,0,0,0, 0,1,0,0,1,4'd1));
    step(v("t_idle", 0,4'h0, 0,0,0,0, 0,0,0,0,0,4'd0));
    // Dispenser stalls for 10 cycles; coins rejected, cancel ignored.
    step(v("h_sel",  1,4'h1, 0,0,0,0, 0,0,0,0,0,4'd0));
    step(v("h_ten1", 0,4'h0, 0,1,0,0, 0,0,0,0,1,4'd0));
    step(v("h_ten2", 0,4'h0, 0,1,0,0, 0,0,0,0,1,4'd2));
    for (int i = 0; i < 10; i++) begin
      logic f;
      f = (i % 2) == 0;
      step(v("h_hold", 0,4'h0, f,0,!f,0, 1,0,f,0,1,4'd4));
    end
    step(v("h_ack",  0,4'h0, 0,0,0,1, 1,0,0,0,1,4'd4));
    step(v("h_idle", 0,4'h0, 0,0,0,0, 0,0,0,0,0,4'd0));
    // Reset asserted during a refund: outputs drop at once, no further pulses.
    step(v("r_sel",    1,4'h8, 0,0,0,0, 0,0,0,0,0,4'd0));
    step(v("r_ten1",   0,4'h0, 0,1,0,0, 0,0,0,0,1,4'd0));
    step(v("r_ten2",   0,4'h0, 0,1,0,0, 0,0,0,0,1,4'd2));
    step(v("r_ten3",   0,4'h0, 0,1,0,0, 0,0,0,0,1,4'd4));
    step(v("r_cancel", 0,4'h0, 0,0,1,0, 0,0,0,0,1,4'd6));
    step(v("r_ref6",   0,4'h0, 0,0,0,0, 0,1,0,0,1,4'd6));
    rst_n = 1'b0;
    #1 cmp("r_async_reset", 9'd0);
    bus.five_rup = 1'b1;
    #1 cmp("r_coin_in_reset", 9'd0);
    bus.five_rup = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step(v("r_idle", 0,4'h0, 0,0,0,0, 0,0,0,0,0,4'd0));
    step(v("r_five", 0,4'h0, 1,0,0,0, 0,0,1,0,0,4'd0));
    step(v("r_end",  0,4'h0, 0,0,0,0, 0,0,0,0,0,4'd0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
